// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared widths, kernel weights, FSM encoding and helpers for the 3x3 gaussian window
package img_pkg;

  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int SUM_W = 12;
  localparam int COL_W = 11;
  localparam int ROW_W = 10;

  // Kernel [1 2 1; 2 4 2; 1 2 1]
  localparam logic [2:0] K_CORNER = 3'd1;
  localparam logic [2:0] K_EDGE   = 3'd2;
  localparam logic [2:0] K_CENTER = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic logic [SUM_W-1:0] wmul(input logic [CH_W-1:0] p, input logic [2:0] w);
    return SUM_W'(p) * SUM_W'(w);
  endfunction

  // Weights total 16, so round-half-up then divide by 16; the max is 255, never saturates
  function automatic logic [CH_W-1:0] round_sum(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
    t = s + SUM_W'(8);
    return t[SUM_W-1 -: CH_W];
  endfunction

endpackage

// File: rtl/gauss_mac_ch.sv
// rtl/gauss_mac_ch.sv - one colour channel of the 3x3 weighted sum, registered
module gauss_mac_ch
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CH_W-1:0]  p00,
  input  logic [CH_W-1:0]  p01,
  input  logic [CH_W-1:0]  p02,
  input  logic [CH_W-1:0]  p10,
  input  logic [CH_W-1:0]  p11,
  input  logic [CH_W-1:0]  p12,
  input  logic [CH_W-1:0]  p20,
  input  logic [CH_W-1:0]  p21,
  input  logic [CH_W-1:0]  p22,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] sum_c;

  // Weighted sum of the window; row 0 is the row above, column 0 the left column
  always_comb begin
    sum_c = wmul(p00, K_CORNER) + wmul(p01, K_EDGE)   + wmul(p02, K_CORNER)
          + wmul(p10, K_EDGE)   + wmul(p11, K_CENTER) + wmul(p12, K_EDGE)
          + wmul(p20, K_CORNER) + wmul(p21, K_EDGE)   + wmul(p22, K_CORNER);
  end

  // Sum register forms the second pipeline stage
  always_ff @(posedge clk) begin
    if (reset) sum <= '0;
    else       sum <= sum_c;
  end

endmodule

// File: rtl/img_gauss_window.sv
// rtl/img_gauss_window.sv - 3x3 gaussian filter over column beats with row/frame sequencing
module img_gauss_window #(
  parameter int PIX_W = 24,
  parameter int CH_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      img_width,
  input  logic [9:0]       img_height,
  input  logic [PIX_W-1:0] next_img_data,
  input  logic [PIX_W-1:0] cur_img_data,
  input  logic [PIX_W-1:0] last_img_data,
  input  logic             valid_i,
  output logic [PIX_W-1:0] data_o,
  output logic             valid_o,
  output logic             frame_done_o,
  output logic             overrun_o
);
  import img_pkg::*;

  state_t                      state;
  logic [COL_W-1:0]            col_cnt;
  logic [ROW_W-1:0]            row_cnt;

  // Window columns; index 0 = row above, 1 = centre row, 2 = row below
  logic [2:0][PIX_W-1:0]       col_l;
  logic [2:0][PIX_W-1:0]       col_c;
  logic [2:0][PIX_W-1:0]       col_r;
  logic [2:0][PIX_W-1:0]       new_col;

  logic                        s1_valid;
  logic                        s1_last;
  logic                        s2_valid;
  logic                        s2_last;
  logic [2:0][SUM_W-1:0]       sum_ch;
  logic [PIX_W-1:0]            rnd_pix;

  assign new_col = {next_img_data, cur_img_data, last_img_data};

  // Row sequencer and window shift; stage 1 of the pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      col_l     <= '0;
      col_c     <= '0;
      col_r     <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      overrun_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            // Column 0 enters with a zero column as its left neighbour
            col_l   <= '0;
            col_c   <= '0;
            col_r   <= new_col;
            col_cnt <= COL_W'(1);
            state   <= (img_width == 11'd1) ? ST_FLUSH : ST_FILL;
          end
        end
        ST_FILL: begin
          if (valid_i) begin
            col_l    <= col_c;
            col_c    <= col_r;
            col_r    <= new_col;
            s1_valid <= 1'b1;
            col_cnt  <= col_cnt + COL_W'(1);
            state    <= (img_width == 11'd2) ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (valid_i) begin
            col_l    <= col_c;
            col_c    <= col_r;
            col_r    <= new_col;
            s1_valid <= 1'b1;
            col_cnt  <= col_cnt + COL_W'(1);
            if (col_cnt == img_width - 11'd1) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // A zero column becomes the right neighbour of the last column; any beat here is dropped
          col_l     <= col_c;
          col_c     <= col_r;
          col_r     <= '0;
          s1_valid  <= 1'b1;
          s1_last   <= (row_cnt == img_height - 10'd1);
          row_cnt   <= (row_cnt == img_height - 10'd1) ? '0 : row_cnt + ROW_W'(1);
          col_cnt   <= '0;
          overrun_o <= valid_i;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    // ch 0 = B, 1 = G, 2 = R
    gauss_mac_ch u_mac (
      .clk   (clk),
      .reset (reset),
      .p00   (col_l[0][ch*CH_W +: CH_W]),
      .p01   (col_c[0][ch*CH_W +: CH_W]),
      .p02   (col_r[0][ch*CH_W +: CH_W]),
      .p10   (col_l[1][ch*CH_W +: CH_W]),
      .p11   (col_c[1][ch*CH_W +: CH_W]),
      .p12   (col_r[1][ch*CH_W +: CH_W]),
      .p20   (col_l[2][ch*CH_W +: CH_W]),
      .p21   (col_c[2][ch*CH_W +: CH_W]),
      .p22   (col_r[2][ch*CH_W +: CH_W]),
      .sum   (sum_ch[ch])
    );
  end

  // Flags follow the sums through stage 2
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  // Round and scale each channel sum back to 8 bits
  always_comb begin
    rnd_pix = '0;
    for (int ch = 0; ch < 3; ch++) rnd_pix[ch*CH_W +: CH_W] = round_sum(sum_ch[ch]);
  end

  // Output register, stage 3; data holds between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      valid_o      <= s2_valid;
      frame_done_o <= s2_valid & s2_last;
      if (s2_valid) data_o <= rnd_pix;
    end
  end

endmodule
